apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Initiator end of the APB memory link: converts single-beat valid/ready commands into
//  APB4 SETUP/ACCESS transfers toward the APB memory slave and returns read data and status.
//  Filters out-of-window addresses locally and bounds slave wait states with a timeout.
//  Sits between a local command source (CPU/DMA shim) and the APB slave port.
// PARAMETERS
//  ADDR_W      20     address width; default taken from apb_package::ADDR_W
//  DATA_W      64     data width; default taken from apb_package::DATA_W; STRB_W = DATA_W/8
//  MEM_SIZE_K  64     slave window size in KB; default taken from apb_package::MEM_SIZE_K
//  BASE_ADDR   0      slave window base; default taken from apb_package::BASE_ADDR
//  TIMEOUT_CYC 16     max ACCESS cycles without PREADY before abort (>=1)
// PORTS
//  pclk        in   1       single clock; all logic on rising edge
//  preset      in   1       reset, synchronous, active-high
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       command accepted when valid&&ready
//  cmd_write   in   1       1=write, 0=read
//  cmd_addr    in   ADDR_W  byte address
//  cmd_wdata   in   DATA_W  write data
//  cmd_strb    in   STRB_W  write byte strobes
//  rsp_valid   out  1       response present; held until rsp_ready
//  rsp_ready   in   1       response consumed when valid&&ready
//  rsp_rdata   out  DATA_W  read data (0 for writes, errors and timeouts)
//  rsp_err     out  1       PSLVERR, decode error or timeout
//  rsp_timeout out  1       error was a timeout
//  PSEL        out  1       APB select
//  PENABLE     out  1       APB enable
//  PWRITE      out  1       APB direction
//  PADDR       out  ADDR_W  APB address
//  PWDATA      out  DATA_W  APB write data
//  PSTRB       out  STRB_W  APB strobes (forced 0 on reads)
//  PRDATA      in   DATA_W  APB read data
//  PREADY      in   1       APB ready
//  PSLVERR     in   1       APB slave error
// BEHAVIOUR
//  - Reset (preset=1 at edge): state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR/PWDATA/PSTRB=0,
//    rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, timeout counter=0. Reset mid-transfer
//    drops PSEL/PENABLE at that edge; in-flight command and pending response are discarded.
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE; decode error goes IDLE -> RESP.
//  - IDLE: cmd_ready=1 only here. On accept, register write/addr/wdata/strb.
//  - Window check at accept: addr in [BASE_ADDR, BASE_ADDR+MEM_SIZE_K*1024-1], computed at
//    ADDR_W+1 bits (no wrap). Out of range: no APB activity, next cycle RESP, err=1, timeout=0.
//  - SETUP: exactly one cycle with PSEL=1, PENABLE=0. PADDR/PWRITE/PWDATA/PSTRB stay
//    constant from SETUP through the last ACCESS cycle.
//  - ACCESS: PSEL=PENABLE=1. Counter increments each ACCESS cycle with PREADY=0.
//    PREADY=1: sample PRDATA (reads only) and PSLVERR, go to RESP; PSEL=PENABLE=0 next cycle.
//    Counter==TIMEOUT_CYC-1 with PREADY=0: abort, PSEL=PENABLE=0 next cycle, RESP with
//    err=1, timeout=1. PREADY=1 on that same cycle wins (normal completion).
//  - RESP: rsp_valid=1; rdata/err/timeout stable until rsp_ready=1, then IDLE.
//    cmd_ready=0 throughout.
//  - Latency: accept at edge N -> PSEL at N+1 -> PENABLE at N+2 -> rsp_valid at N+3 with
//    zero wait states. Issue rate: min 4 cycles per transfer (RESP->IDLE->accept).
//  - PSEL never asserted outside SETUP/ACCESS; PENABLE never without PSEL; no back-to-back
//    ACCESS without an intervening IDLE.
// STRUCTURE
//  - apb_package additions: apb_mst_state_e (IDLE/SETUP/ACCESS/RESP), STRB_W=DATA_W/8,
//    WIN_LO/WIN_HI derived from BASE_ADDR and MEM_SIZE_K.
//  - One sub-module: apb_wait_timer (clear/enable/expired, width $clog2(TIMEOUT_CYC+1)).
//  - Remaining logic (FSM, command/response registers) lives in this module.
// TESTING
//  1 Write addr=0x00100, wdata=0xDEAD_BEEF_0123_4567, strb=0xFF, PREADY=1 -> PSEL@N+1,
//    PENABLE@N+2, rsp_valid@N+3, err=0.
//  2 Read addr=0x00100, slave 3 wait states, PRDATA=0xA5A5 -> rdata=0xA5A5, PSTRB=0,
//    PADDR stable all 5 APB cycles.
//  3 Read addr=0x10000 (one past 64KB) -> no PSEL, rsp_valid next cycle, err=1, timeout=0.
//  4 PREADY stuck 0 -> PENABLE high exactly 16 cycles, then rsp err=1, timeout=1, rdata=0.
//  5 Slave PSLVERR=1 on write, rsp_ready held 0 for 5 cycles -> rsp stable,
//    cmd_ready=0 throughout.
//  6 preset=1 during ACCESS -> PSEL/PENABLE=0 next cycle, no rsp_valid; new command
//    completes normally.

Source files
------------

// File: rtl/apb_package.sv
// ============================================================================
//  Package : apb_package
//  Purpose : Shared constants and types for the APB memory link. Holds the
//            default bus geometry, the slave address window and the state
//            encoding of the APB initiator bridge.
//  Contents: ADDR_W, DATA_W, STRB_W, MEM_SIZE_K, BASE_ADDR, WIN_LO, WIN_HI,
//            apb_mst_state_e
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_package;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 64;
  localparam int STRB_W     = DATA_W / 8;
  localparam int MEM_SIZE_K = 64;

  localparam logic [ADDR_W-1:0] BASE_ADDR = '0;

  // Window bounds carry one extra bit so a window ending exactly at the top
  // of the address space does not wrap back to zero.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(MEM_SIZE_K * 1024)
                                       - (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
//  Module  : apb_wait_timer
//  Purpose : Counts APB ACCESS cycles spent waiting for PREADY and flags the
//            last permitted wait cycle.
//  Ports   : clk_i      - clock, rising edge
//            rst_i      - synchronous active-high reset
//            clear_i    - return count to zero (has priority over en_i)
//            en_i       - count one waited cycle
//            expired_o  - count has reached TIMEOUT_CYC-1
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted during the final ACCESS cycle the slave is allowed to stall.
  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
//  Module  : apb_master_bridge
//  Purpose : APB4 initiator. Turns single-beat valid/ready commands into
//            SETUP/ACCESS transfers, rejects out-of-window addresses without
//            touching the bus, bounds slave wait states with a timeout and
//            returns read data and status on a held valid/ready response.
//  Ports   : pclk, preset                 - clock / sync active-high reset
//            cmd_valid/ready/write/addr/wdata/strb - command channel
//            rsp_valid/ready/rdata/err/timeout     - response channel
//            PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
//            PRDATA, PREADY, PSLVERR      - APB4 initiator port
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge #(
  parameter int                ADDR_W      = apb_package::ADDR_W,
  parameter int                DATA_W      = apb_package::DATA_W,
  parameter int                MEM_SIZE_K  = apb_package::MEM_SIZE_K,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = apb_package::BASE_ADDR,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB initiator
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  import apb_package::*;

  localparam int STRB_LW = DATA_W / 8;

  // Window test is done as an offset from the base: a borrow out of the
  // subtraction means the address is below the window.
  localparam logic [ADDR_W:0] WIN_SPAN = (ADDR_W+1)'(MEM_SIZE_K * 1024)
                                         - (ADDR_W+1)'(1);

  apb_mst_state_e state_q, state_d;

  logic                 write_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [STRB_LW-1:0]   strb_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;
  logic                 tmo_q;

  logic                 accept;
  logic                 addr_in_win;
  logic [ADDR_W+1:0]    addr_off;
  logic                 access_done;
  logic                 access_abort;
  logic                 timer_clear;
  logic                 timer_en;
  logic                 timer_expired;

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  assign accept      = cmd_valid && (state_q == IDLE);
  assign addr_off    = {2'b00, cmd_addr} - {2'b00, BASE_ADDR};
  assign addr_in_win = !addr_off[ADDR_W+1] && (addr_off[ADDR_W:0] <= WIN_SPAN);

  // PREADY on the expiring cycle is a normal completion, so abort requires it low.
  assign access_done  = (state_q == ACCESS) && PREADY;
  assign access_abort = (state_q == ACCESS) && !PREADY && timer_expired;

  // --------------------------------------------------------------------------
  // Wait-state timer
  // --------------------------------------------------------------------------
  assign timer_clear = (state_q != ACCESS);
  assign timer_en    = (state_q == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk_i     (pclk),
    .rst_i     (preset),
    .clear_i   (timer_clear),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = addr_in_win ? SETUP : RESP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (access_done || access_abort) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   PSEL      = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (preset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (accept) begin
        if (addr_in_win) begin
          // Bus-facing registers only move for commands that reach the bus,
          // so a rejected command leaves the APB outputs untouched.
          write_q <= cmd_write;
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          strb_q  <= cmd_write ? cmd_strb : '0;
        end else begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          tmo_q   <= 1'b0;
        end
      end else if (access_done) begin
        rdata_q <= write_q ? '0 : PRDATA;
        err_q   <= PSLVERR;
        tmo_q   <= 1'b0;
      end else if (access_abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        tmo_q   <= 1'b1;
      end
    end
  end

  assign PWRITE      = write_q;
  assign PADDR       = addr_q;
  assign PWDATA      = wdata_q;
  assign PSTRB       = strb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
//  Module  : tb_apb_master_bridge
//  Purpose : Directed self-checking bench for apb_master_bridge with the
//            default 20-bit address / 64-bit data / 64 KB window at base 0.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [19:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [19:0] PADDR;
  logic [63:0] PWDATA;
  logic [7:0]  PSTRB;
  logic [63:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_bridge u_dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Present a command while the bridge is idle; it is taken at the next edge.
  task automatic send(input logic w, input logic [19:0] a, input logic [63:0] d,
                      input logic [7:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int pen_cnt;

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check_eq("rst_psel",    64'(PSEL),        64'd0);
    check_eq("rst_penable", 64'(PENABLE),     64'd0);
    check_eq("rst_pwrite",  64'(PWRITE),      64'd0);
    check_eq("rst_paddr",   64'(PADDR),       64'd0);
    check_eq("rst_pwdata",  PWDATA,           64'd0);
    check_eq("rst_pstrb",   64'(PSTRB),       64'd0);
    check_eq("rst_rvalid",  64'(rsp_valid),   64'd0);
    check_eq("rst_rerr",    64'(rsp_err),     64'd0);
    check_eq("rst_rtmo",    64'(rsp_timeout), 64'd0);
    check_eq("rst_rdata",   rsp_rdata,        64'd0);
    check_eq("rst_cready",  64'(cmd_ready),   64'd1);
    preset = 1'b0;
    tick();

    // ---------------- 1: zero-wait write, latency ----------------
    PREADY = 1'b1;
    send(1'b1, 20'h00100, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    check_eq("t1_n1_psel",    64'(PSEL),      64'd1);
    check_eq("t1_n1_penable", 64'(PENABLE),   64'd0);
    check_eq("t1_n1_cready",  64'(cmd_ready), 64'd0);
    check_eq("t1_paddr",      64'(PADDR),     64'h00100);
    check_eq("t1_pwrite",     64'(PWRITE),    64'd1);
    check_eq("t1_pwdata",     PWDATA,         64'hDEAD_BEEF_0123_4567);
    check_eq("t1_pstrb",      64'(PSTRB),     64'hFF);
    tick();
    check_eq("t1_n2_psel",    64'(PSEL),      64'd1);
    check_eq("t1_n2_penable", 64'(PENABLE),   64'd1);
    check_eq("t1_n2_rvalid",  64'(rsp_valid), 64'd0);
    tick();
    check_eq("t1_n3_rvalid",  64'(rsp_valid), 64'd1);
    check_eq("t1_n3_psel",    64'(PSEL),      64'd0);
    check_eq("t1_err",        64'(rsp_err),   64'd0);
    check_eq("t1_rdata",      rsp_rdata,      64'd0);
    consume();
    check_eq("t1_done_rvalid", 64'(rsp_valid), 64'd0);
    check_eq("t1_done_cready", 64'(cmd_ready), 64'd1);

    // ---------------- 2: read with 3 wait states ----------------
    PREADY = 1'b0;
    PRDATA = 64'hA5A5;
    send(1'b0, 20'h00100, 64'h1111_2222_3333_4444, 8'hFF);
    check_eq("t2_setup_psel",  64'(PSEL),   64'd1);
    check_eq("t2_setup_paddr", 64'(PADDR),  64'h00100);
    check_eq("t2_pstrb",       64'(PSTRB),  64'd0);
    check_eq("t2_pwrite",      64'(PWRITE), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_acc_penable", 64'(PENABLE), 64'd1);
      check_eq("t2_acc_paddr",   64'(PADDR),   64'h00100);
      if (i == 3) PREADY = 1'b1;
    end
    tick();
    PREADY = 1'b0;
    check_eq("t2_rvalid", 64'(rsp_valid), 64'd1);
    check_eq("t2_rdata",  rsp_rdata,      64'hA5A5);
    check_eq("t2_err",    64'(rsp_err),   64'd0);
    check_eq("t2_psel",   64'(PSEL),      64'd0);
    consume();

    // ---------------- 3: decode error one past window ----------------
    send(1'b0, 20'h10000, 64'd0, 8'h00);
    check_eq("t3_psel",   64'(PSEL),        64'd0);
    check_eq("t3_rvalid", 64'(rsp_valid),   64'd1);
    check_eq("t3_err",    64'(rsp_err),     64'd1);
    check_eq("t3_tmo",    64'(rsp_timeout), 64'd0);
    check_eq("t3_rdata",  rsp_rdata,        64'd0);
    consume();

    // last in-window byte completes normally
    PREADY = 1'b1;
    PRDATA = 64'h0BAD_F00D;
    send(1'b0, 20'h0FFFF, 64'd0, 8'h00);
    check_eq("t3b_psel", 64'(PSEL), 64'd1);
    tick();
    tick();
    check_eq("t3b_rvalid", 64'(rsp_valid), 64'd1);
    check_eq("t3b_err",    64'(rsp_err),   64'd0);
    check_eq("t3b_rdata",  rsp_rdata,      64'h0BAD_F00D);
    consume();

    // ---------------- 4: timeout ----------------
    PREADY = 1'b0;
    PRDATA = 64'hFFFF_FFFF;
    send(1'b0, 20'h00200, 64'd0, 8'h00);
    pen_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!PENABLE) break;
      pen_cnt++;
    end
    check_eq("t4_penable_cycles", 64'(pen_cnt), 64'd16);
    check_eq("t4_psel",   64'(PSEL),        64'd0);
    check_eq("t4_rvalid", 64'(rsp_valid),   64'd1);
    check_eq("t4_err",    64'(rsp_err),     64'd1);
    check_eq("t4_tmo",    64'(rsp_timeout), 64'd1);
    check_eq("t4_rdata",  rsp_rdata,        64'd0);
    consume();

    // ---------------- 5: PSLVERR with held response ----------------
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    send(1'b1, 20'h00300, 64'h55, 8'h0F);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 20'h00400;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_rvalid", 64'(rsp_valid),   64'd1);
      check_eq("t5_err",    64'(rsp_err),     64'd1);
      check_eq("t5_tmo",    64'(rsp_timeout), 64'd0);
      check_eq("t5_rdata",  rsp_rdata,        64'd0);
      check_eq("t5_cready", 64'(cmd_ready),   64'd0);
      check_eq("t5_psel",   64'(PSEL),        64'd0);
      tick();
    end
    cmd_valid = 1'b0;
    PSLVERR   = 1'b0;
    consume();
    check_eq("t5_done_rvalid", 64'(rsp_valid), 64'd0);
    check_eq("t5_done_psel",   64'(PSEL),      64'd0);

    // ---------------- 6: reset during ACCESS ----------------
    PREADY = 1'b0;
    send(1'b0, 20'h00400, 64'd0, 8'h00);
    tick();
    check_eq("t6_acc_penable", 64'(PENABLE), 64'd1);
    preset = 1'b1;
    tick();
    check_eq("t6_rst_psel",    64'(PSEL),      64'd0);
    check_eq("t6_rst_penable", 64'(PENABLE),   64'd0);
    check_eq("t6_rst_rvalid",  64'(rsp_valid), 64'd0);
    preset = 1'b0;
    tick();
    check_eq("t6_post_rvalid", 64'(rsp_valid), 64'd0);
    check_eq("t6_post_cready", 64'(cmd_ready), 64'd1);
    PREADY = 1'b1;
    PRDATA = 64'h1234_5678_9ABC_DEF0;
    send(1'b0, 20'h00008, 64'd0, 8'h00);
    check_eq("t6_new_psel", 64'(PSEL), 64'd1);
    tick();
    tick();
    check_eq("t6_new_rvalid", 64'(rsp_valid), 64'd1);
    check_eq("t6_new_rdata",  rsp_rdata,      64'h1234_5678_9ABC_DEF0);
    check_eq("t6_new_err",    64'(rsp_err),   64'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

`default_nettype wire
